audio_predelay_stream: RTL and testbench

//  Fabric-side audio stage at the far end of the codec's Avalon-ST left-channel link. Consumes

---
 rtl/audio_predelay_stream_if.sv | 13 +
 rtl/audio_predelay_stream.sv | 113 +++++++++++
 tb/tb_audio_predelay_stream.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/audio_predelay_stream_if.sv
// rtl/audio_predelay_stream_if.sv - Avalon-ST style sample stream (data/valid/ready)
//  master : drives data, valid; samples ready
//  slave  : samples data, valid; drives ready
interface audio_predelay_stream_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/audio_predelay_stream.sv
// rtl/audio_predelay_stream.sv - circular-buffer audio predelay on a ready/valid sample stream
//  clk_clk         single system clock
//  reset_reset_n   asynchronous active-low reset
//  snk             input sample stream (slave): data, valid, ready
//  src             delayed sample stream (master): data, valid, ready
//  predelay_value  requested delay in samples, clamped to DEPTH-1, sampled once per accept
//  flush           (PREDELAY_FLUSH_EN only) sync active-high history clear
//  fill_level      valid history depth, saturates at DEPTH
//  Optional feature macro: PREDELAY_FLUSH_EN
module audio_predelay_stream #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 10
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    audio_predelay_stream_if.slave  snk,
    audio_predelay_stream_if.master src,
    input  logic [23:0]             predelay_value,
`ifdef PREDELAY_FLUSH_EN
    input  logic                    flush,
`endif
    output logic [ADDR_W:0]         fill_level
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, OUT = 2'd2} state_t;
    typedef enum logic [1:0] {SEL_BYPASS = 2'd0, SEL_ZERO = 2'd1, SEL_MEM = 2'd2} sel_t;

    state_t            state, state_nxt;
    sel_t              sel;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] d;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] byp_word;
    logic [DATA_W-1:0] src_data_q;
    logic              accept;
    logic              clear;

`ifdef PREDELAY_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    assign d       = (predelay_value > 24'(DEPTH - 1)) ? ADDR_W'(DEPTH - 1)
                                                       : predelay_value[ADDR_W-1:0];
    assign rd_addr = wr_ptr - d;
    // Flush beats a simultaneous handshake: the sample is neither written nor counted.
    assign accept  = (state == IDLE) && snk.valid && !clear;
    assign src.data = src_data_q;

    always_comb begin
        state_nxt = state;
        snk.ready = 1'b0;
        src.valid = 1'b0;
        case (state)
            IDLE: begin
                snk.ready = 1'b1;
                if (snk.valid) state_nxt = RD;
            end
            RD:  state_nxt = OUT;
            OUT: begin
                src.valid = 1'b1;
                if (src.ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            fill_level <= '0;
            sel        <= SEL_ZERO;
            src_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                wr_ptr     <= '0;
                fill_level <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill_level != (ADDR_W + 1)'(DEPTH)) fill_level <= fill_level + 1'b1;
                // Decided against the pre-increment fill level so the in-flight
                // sample is immune to later predelay changes.
                if (d == '0)                     sel <= SEL_BYPASS;
                else if ({1'b0, d} > fill_level) sel <= SEL_ZERO;
                else                             sel <= SEL_MEM;
            end
            if (state == RD && !clear) begin
                case (sel)
                    SEL_BYPASS: src_data_q <= byp_word;
                    SEL_MEM:    src_data_q <= rd_word;
                    default:    src_data_q <= '0;
                endcase
            end
        end
    end

    // Buffer is deliberately not reset. With d>0 the read address never equals
    // the write address, so no read-during-write ordering question arises.
    always_ff @(posedge clk_clk) begin
        if (accept) begin
            mem[wr_ptr] <= snk.data;
            rd_word     <= mem[rd_addr];
            byp_word    <= snk.data;
        end
    end
endmodule

// File: tb/tb_audio_predelay_stream.sv
// tb/tb_audio_predelay_stream.sv - self-checking bench for audio_predelay_stream (ADDR_W=4)
module tb_audio_predelay_stream;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] predelay_value = '0;
    logic [ADDR_W:0] fill_level;
`ifdef PREDELAY_FLUSH_EN
    logic        flush = 1'b0;
`endif

    audio_predelay_stream_if #(.DATA_W(DATA_W)) snk_if();
    audio_predelay_stream_if #(.DATA_W(DATA_W)) src_if();

    audio_predelay_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .snk            (snk_if),
        .src            (src_if),
        .predelay_value (predelay_value),
`ifdef PREDELAY_FLUSH_EN
        .flush          (flush),
`endif
        .fill_level     (fill_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] hist[$];

    typedef struct {
        logic        rst;
        logic [23:0] pd;
        logic [23:0] x;
        logic [23:0] y;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: full input history since the last clear; output is the sample
    // d places back, zero if that far back does not exist yet.
    function automatic logic [23:0] model_expect(input logic [23:0] x, input logic [23:0] pv);
        int d;
        int n;
        d = (pv > 24'd15) ? 15 : int'(pv);
        n = hist.size();
        if (d == 0) return x;
        if (d > n)  return 24'd0;
        return hist[n - d];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        @(negedge clk);
    endtask

    task automatic xfer(input logic [23:0] x, input logic [23:0] pv, input int stall,
                        output logic [23:0] y);
        int n;
        int fexp;
        y = '0;
        @(negedge clk);
        predelay_value = pv;
        snk_if.data    = x;
        snk_if.valid   = 1'b1;
        src_if.ready   = (stall == 0);
        n = 0;
        while (!snk_if.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!snk_if.ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            snk_if.valid = 1'b0;
            return;
        end
        @(negedge clk);
        snk_if.valid   = 1'b0;
        snk_if.data    = 24'($urandom);
        predelay_value = 24'($urandom);
        hist.push_back(x);
        fexp = (hist.size() > DEPTH) ? DEPTH : hist.size();
        chk("rd_snk_ready", 32'(snk_if.ready), 32'd0);
        chk("rd_src_valid", 32'(src_if.valid), 32'd0);
        chk("fill_level", 32'(fill_level), fexp);
        @(negedge clk);
        chk("latency_src_valid", 32'(src_if.valid), 32'd1);
        y = src_if.data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_src_valid", 32'(src_if.valid), 32'd1);
            chk("stall_src_data", 32'(src_if.data), 32'(y));
            chk("stall_snk_ready", 32'(snk_if.ready), 32'd0);
        end
        src_if.ready = 1'b1;
        @(negedge clk);
        chk("post_hs_src_valid", 32'(src_if.valid), 32'd0);
        chk("post_hs_snk_ready", 32'(snk_if.ready), 32'd1);
    endtask

    initial begin
        logic [23:0] y;
        logic [23:0] e;
        logic [23:0] x;
        logic [23:0] pv;

        snk_if.data  = '0;
        snk_if.valid = 1'b0;
        src_if.ready = 1'b1;

        for (int i = 0; i < 5; i++)
            tbl[i] = '{rst: (i == 0), pd: 24'd0, x: 24'(i + 1), y: 24'(i + 1)};
        for (int k = 1; k <= 8; k++)
            tbl[k + 4] = '{rst: (k == 1), pd: 24'd3, x: 24'(k),
                           y: (k > 3) ? 24'(k - 3) : 24'd0};

        do_reset();
        chk("reset_src_valid", 32'(src_if.valid), 32'd0);
        chk("reset_snk_ready", 32'(snk_if.ready), 32'd1);
        chk("reset_fill_level", 32'(fill_level), 32'd0);
        chk("reset_src_data", 32'(src_if.data), 32'd0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            xfer(tbl[i].x, tbl[i].pd, 0, y);
            chk($sformatf("table_%0d", i), 32'(y), 32'(tbl[i].y));
        end

        // d=3 over 40 random samples: pointer wrap and fill saturation
        do_reset();
        for (int k = 0; k < 40; k++) begin
            x = 24'($urandom);
            e = model_expect(x, 24'd3);
            xfer(x, 24'd3, 0, y);
            chk("wrap_d3", 32'(y), 32'(e));
        end
        chk("fill_saturated", 32'(fill_level), 32'd16);

        // clamp: 0xFF behaves as 15
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            e = model_expect(24'(k), 24'h0000FF);
            xfer(24'(k), 24'h0000FF, 0, y);
            chk("clamp_model", 32'(y), 32'(e));
        end
        chk("clamp_out20", 32'(y), 32'h000005);

        // long backpressure
        do_reset();
        for (int k = 0; k < 3; k++) begin
            x = 24'($urandom);
            e = model_expect(x, 24'd1);
            xfer(x, 24'd1, 10, y);
            chk("stall10", 32'(y), 32'(e));
        end

        // random delays, data and stalls
        for (int k = 0; k < 80; k++) begin
            x  = 24'($urandom);
            pv = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 20));
            e  = model_expect(x, pv);
            xfer(x, pv, $urandom_range(0, 3), y);
            chk("random", 32'(y), 32'(e));
        end

        // reset while in RD
        @(negedge clk);
        predelay_value = '0; snk_if.data = 24'h123; snk_if.valid = 1'b1; src_if.ready = 1'b1;
        @(negedge clk);
        snk_if.valid = 1'b0;
        chk("midrd_in_rd", 32'(snk_if.ready), 32'd0);
        #1 rst_n = 1'b0;
        #1 chk("midrd_async_src_valid", 32'(src_if.valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        @(negedge clk);
        chk("midrd_snk_ready", 32'(snk_if.ready), 32'd1);
        chk("midrd_src_valid", 32'(src_if.valid), 32'd0);
        chk("midrd_fill", 32'(fill_level), 32'd0);

        // reset while presenting in OUT
        src_if.ready = 1'b0; snk_if.data = 24'h456; snk_if.valid = 1'b1;
        @(negedge clk);
        snk_if.valid = 1'b0;
        @(negedge clk);
        chk("midout_valid_before", 32'(src_if.valid), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("midout_async_src_valid", 32'(src_if.valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; src_if.ready = 1'b1;
        hist.delete();
        x = 24'h00ABCD;
        e = model_expect(x, 24'd2);
        xfer(x, 24'd2, 0, y);
        chk("after_reset_empty_history", 32'(y), 32'(e));

`ifdef PREDELAY_FLUSH_EN
        do_reset();
        for (int k = 1; k <= 6; k++) xfer(24'(k), 24'd2, 0, y);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        hist.delete();
        chk("flush_fill", 32'(fill_level), 32'd0);
        xfer(24'h0000A1, 24'd2, 0, y);
        chk("flush_out0", 32'(y), 32'd0);
        xfer(24'h0000A2, 24'd2, 0, y);
        chk("flush_out1", 32'(y), 32'd0);
        xfer(24'h0000A3, 24'd2, 0, y);
        chk("flush_out2", 32'(y), 32'h0000A1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
